axis_frame_host: RTL and testbench
==================================

# axis_frame_host

Host-side AXI-Stream frame engine that drives the `vip_axis` wrapper from its stream side. On a start pulse it serializes a wide parallel frame onto an AXI-Stream master, which feeds the VIP's slave port, asserting `tlast` on the final word. It then collects the VIP's response frame from an AXI-Stream slave into a wide parallel register and reports `done`/`error`. It sits between a test sequencer or CPU-side register block and `vip_axis`, inside the accelerator IP.

## Interface
- `C_DATA_WIDTH`, 128, stream word width in bits (multiple of 8).
- `TX_WORDS_NUM`, 10, words per transmitted frame; must be ≥ 1.
- `RX_WORDS_NUM`, 10, words per received frame; must be ≥ 1.
- `TIMEOUT_CYCLES`, 1024, receive watchdog limit; used only with `AXIS_FRAME_HOST_TIMEOUT_EN`.

- `axis_aclk`  in  1  single clock for all logic.
- `axis_areset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at frame completion.
- `error`  out  1  sticky per frame; valid with `done`; cleared on the next accepted `start`.
- `tx_bus`  in  C_DATA_WIDTH*TX_WORDS_NUM  outgoing frame; word k is `[k*C_DATA_WIDTH +: C_DATA_WIDTH]`.
- `rx_bus`  out  C_DATA_WIDTH*RX_WORDS_NUM  received frame, using the same word ordering as `tx_bus`.
- `m_axis_tvalid`/`m_axis_tready`/`m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`  out/in/out/out/out  1/1/C_DATA_WIDTH/C_DATA_WIDTH/8/1  transmit stream.
- `s_axis_tvalid`/`s_axis_tready`/`s_axis_tdata`/`s_axis_tkeep`/`s_axis_tlast`  in/out/in/in/in  1/1/C_DATA_WIDTH/C_DATA_WIDTH/8/1  receive stream.

## Operation
- The FSM has four states: IDLE, TX, RX, DONE.
- IDLE → TX on `start`:
  - latch `tx_bus` into an internal frame register;
  - clear `error`;
  - reset the word index.
- TX:
  - `m_axis_tvalid` = 1, `m_axis_tdata` = word[idx], `m_axis_tkeep` = all ones.
  - `m_axis_tlast` = 1 only when idx = TX_WORDS_NUM-1.
  - idx advances on each handshake (`tvalid & tready`).
  - After the last handshake → RX, and idx clears.
- RX:
  - `s_axis_tready` = 1.
  - Each beat writes `s_axis_tdata` into rx word[idx]; `s_axis_tkeep` is ignored.
  - `error` is set if `tlast` = 1 on any beat other than the last, or `tlast` = 0 on the last beat.
  - All RX_WORDS_NUM beats are always consumed.
  - After the last beat → DONE.
- DONE:
  - `done` = 1 for exactly one cycle, then the FSM returns to IDLE.
- `start` outside IDLE is ignored.
- `rx_bus` holds its contents until overwritten by the next frame's beats.
- Index counters are `$clog2(max(TX_WORDS_NUM, RX_WORDS_NUM))` bits wide, with no wrap past the last index.

## Timing
- All outputs are registered.
- Values after reset:
  - FSM returns to IDLE;
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tkeep`, `s_axis_tready`, `busy`, `done` and `error` are all 0;
  - `rx_bus` = 0.
- If `start` is high at edge N, `m_axis_tvalid` is high from N+1 with word 0.
- `m_axis_tdata`/`m_axis_tlast` stay stable while `tvalid & !tready`.
- With `tready` held high, words go out back-to-back: the TX phase lasts exactly TX_WORDS_NUM cycles.
- `s_axis_tready` rises on the cycle after the last TX handshake.
- `done` asserts on the cycle after the last RX beat.
- Minimum frame latency (ready/valid held high on both streams): TX_WORDS_NUM + RX_WORDS_NUM + 1 cycles from `start` to `done`.
- Reset asserted mid-frame takes effect at the next edge. `tvalid` drops immediately and the frame is abandoned with no `done`.

## Configuration
- `AXIS_FRAME_HOST_TIMEOUT_EN` defined:
  - a watchdog counts consecutive RX cycles with no beat;
  - it is cleared on every beat;
  - when it reaches TIMEOUT_CYCLES, `error` = 1 and the FSM → DONE, leaving partial `rx_bus` contents in place.
- Undefined: no watchdog logic is built, and RX waits indefinitely.

## Structure
- Shared package `acc_axis_pkg` holds the FSM state enum `axis_host_state_t` (IDLE, TX, RX, DONE).
- No sub-modules; the TX mux, RX demux and FSM stay in one file.

## Test plan
- Loopback through `vip_axis` with WORDS_NUM = 10 and `tx_bus` word k = k+1:
  - exactly 10 beats go out, with `tlast` on the 10th only;
  - `done` asserts 21 cycles after `start`;
  - `rx_bus` matches `dut2vip_bus`.
- `m_axis_tready` toggling 1,0,0,1,…:
  - no word is dropped or duplicated;
  - `tdata` is stable during stalls.
- RX stream with `tlast` on beat 4 of 10:
  - all 10 beats are accepted;
  - `done` asserts with `error` = 1.
- `start` pulsed during TX: ignored, and exactly one frame is sent.
- Reset asserted in the middle of RX (beat 5):
  - next cycle all outputs = 0 and `rx_bus` = 0;
  - a new `start` then completes normally with `error` = 0.
- With `AXIS_FRAME_HOST_TIMEOUT_EN` defined, TIMEOUT_CYCLES = 16, and `s_axis_tvalid` stuck low after 3 beats:
  - `done` and `error` assert 17 cycles after the 3rd beat;
  - words 0–2 are captured in `rx_bus`.

Source files
------------

// File: rtl/acc_axis_pkg.sv
// Shared definitions for the accelerator AXI-Stream host blocks.
package acc_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2,
    DONE = 2'd3
  } axis_host_state_t;

  // Word-index width able to address the larger of the two frames (at least 1 bit).
  function automatic int idx_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/axis_frame_host.sv
// Host-side AXI-Stream frame engine: serializes tx_bus onto m_axis (tlast on
// the final word), then collects a response frame from s_axis into rx_bus.
// Optional receive watchdog: define AXIS_FRAME_HOST_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// TX    | presenting word[idx] on m_axis, advancing on each handshake
// RX    | s_axis_tready high, writing each beat into rx word[idx]
// DONE  | done pulse cycle, returns to IDLE
module axis_frame_host
  import acc_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 128,
  parameter int TX_WORDS_NUM   = 10,
  parameter int RX_WORDS_NUM   = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               axis_aclk,
  input  logic                               axis_areset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  input  logic [C_DATA_WIDTH*TX_WORDS_NUM-1:0] tx_bus,
  output logic [C_DATA_WIDTH*RX_WORDS_NUM-1:0] rx_bus,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic                               m_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]          s_axis_tkeep,
  input  logic                               s_axis_tlast
);

  localparam int KW = C_DATA_WIDTH / 8;
  localparam int IW = idx_width(TX_WORDS_NUM, RX_WORDS_NUM);
  localparam logic [IW-1:0] TX_LAST = IW'(TX_WORDS_NUM - 1);
  localparam logic [IW-1:0] RX_LAST = IW'(RX_WORDS_NUM - 1);

  axis_host_state_t state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [C_DATA_WIDTH*TX_WORDS_NUM-1:0] frame_q, frame_d;
  logic [C_DATA_WIDTH*RX_WORDS_NUM-1:0] rx_bus_q, rx_bus_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [C_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KW-1:0]    m_tkeep_q, m_tkeep_d;
  logic             m_tlast_q, m_tlast_d;
  logic             s_tready_q, s_tready_d;
  logic             tx_hs, rx_beat;

  // Byte enables on the receive side carry no information for this engine.
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;

`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
  localparam int WDW = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_q, wd_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    rx_bus_d   = rx_bus_q;
    error_d    = error_q;
    done_d     = 1'b0;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    s_tready_d = s_tready_q;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    tx_hs   = m_tvalid_q & m_axis_tready;
    rx_beat = s_tready_q & s_axis_tvalid;
    idx_nxt = idx_q + IW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = TX;
          frame_d    = tx_bus;
          error_d    = 1'b0;
          idx_d      = '0;
          // Word 0 comes straight from tx_bus so it is on the bus one cycle after start.
          m_tvalid_d = 1'b1;
          m_tdata_d  = tx_bus[0 +: C_DATA_WIDTH];
          m_tkeep_d  = '1;
          m_tlast_d  = (TX_WORDS_NUM == 1);
        end
      end
      TX: begin
        if (tx_hs) begin
          if (idx_q == TX_LAST) begin
            state_d    = RX;
            idx_d      = '0;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            s_tready_d = 1'b1;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
            wd_d       = '0;
`endif
          end else begin
            idx_d     = idx_nxt;
            m_tdata_d = frame_q[int'(idx_nxt)*C_DATA_WIDTH +: C_DATA_WIDTH];
            m_tlast_d = (idx_nxt == TX_LAST);
          end
        end
      end
      RX: begin
        if (rx_beat) begin
          rx_bus_d[int'(idx_q)*C_DATA_WIDTH +: C_DATA_WIDTH] = s_axis_tdata;
          // Framing mismatch is recorded but every word is still consumed.
          if (s_axis_tlast != (idx_q == RX_LAST)) error_d = 1'b1;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
          wd_d = '0;
`endif
          if (idx_q == RX_LAST) begin
            state_d    = DONE;
            idx_d      = '0;
            s_tready_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d = idx_nxt;
          end
        end
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d    = DONE;
          idx_d      = '0;
          s_tready_d = 1'b0;
          error_d    = 1'b1;
          done_d     = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      rx_bus_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      s_tready_q <= 1'b0;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      rx_bus_q   <= rx_bus_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      s_tready_q <= s_tready_d;
`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign rx_bus        = rx_bus_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign s_axis_tready = s_tready_q;

endmodule

// File: tb/tb_axis_frame_host.sv
// Self-checking bench for axis_frame_host: table of frame scenarios plus
// hand-written reset-in-RX and (when AXIS_FRAME_HOST_TIMEOUT_EN) watchdog cases.
module tb_axis_frame_host;
  localparam int W  = 128;
  localparam int NT = 10;
  localparam int NR = 10;
  localparam int KW = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset, start, busy, done, error;
  logic [W*NT-1:0] tx_bus;
  logic [W*NR-1:0] rx_bus;
  logic          m_tvalid, m_tready, m_tlast;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [KW-1:0] s_tkeep;

  axis_frame_host #(
    .C_DATA_WIDTH(W), .TX_WORDS_NUM(NT), .RX_WORDS_NUM(NR), .TIMEOUT_CYCLES(16)
  ) dut (
    .axis_aclk(clk), .axis_areset(areset), .start(start),
    .busy(busy), .done(done), .error(error),
    .tx_bus(tx_bus), .rx_bus(rx_bus),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tx_word(input int seed, input int k);
    return {32'(seed), 32'hC0DE_0000 ^ 32'(seed), 32'(k), 32'(k + 1)};
  endfunction

  function automatic logic [W-1:0] rx_word(input int seed, input int k);
    return {32'hBEEF_0000 | 32'(seed), 32'(k), 32'(k) ^ 32'hFFFF_FFFF, 32'(seed * 16 + k)};
  endfunction

  function automatic logic [W*NT-1:0] tx_frame(input int seed);
    logic [W*NT-1:0] f;
    for (int k = 0; k < NT; k++) f[k*W +: W] = tx_word(seed, k);
    return f;
  endfunction

  typedef struct {
    int seed;
    bit tready_toggle;  // m_axis_tready pattern 1,0,0,1 repeating
    bit rx_gaps;        // s_axis_tvalid only on every other ready cycle
    int tlast_at;       // beat index carrying tlast (-1: none)
    int mid_start;      // cycle of a stray start pulse during TX (0: none)
    bit exp_err;
    int exp_lat;        // edges from start-sample edge to done-sample edge
  } vec_t;

  vec_t vecs[6];

  task automatic run_frame(input vec_t v);
    logic [W-1:0] last_data;
    logic last_tlast;
    bit   last_stall;
    int   tx_cnt, tx_step, rx_cnt, rx_step, cyc;
    int   last_tx_edge, first_srdy, last_rx_edge, done_cyc;
    last_data = '0; last_tlast = 1'b0; last_stall = 1'b0;
    tx_cnt = 0; tx_step = 0; rx_cnt = 0; rx_step = 0; cyc = 0;
    last_tx_edge = -1; first_srdy = -1; last_rx_edge = -1; done_cyc = -1;

    tx_bus = tx_frame(v.seed);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_i("start_error_clr", int'(error), 0);
    chk_i("start_busy", int'(busy), 1);
    chk_i("start_tvalid", int'(m_tvalid), 1);

    while (cyc < 400) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = 1'b0;
      if (v.mid_start > 0 && cyc == v.mid_start) begin
        start  = 1'b1;
        tx_bus = tx_frame(v.seed + 100);
      end
      m_tready = 1'b0;
      if (m_tvalid) begin
        if (last_stall) begin
          chk_w("stall_tdata", m_tdata, last_data);
          chk_i("stall_tlast", int'(m_tlast), int'(last_tlast));
        end
        m_tready = v.tready_toggle ? ((tx_step % 4 == 0) || (tx_step % 4 == 3)) : 1'b1;
        tx_step++;
        if (m_tready) begin
          chk_w($sformatf("tx_word%0d", tx_cnt), m_tdata, tx_word(v.seed, tx_cnt));
          chk_i($sformatf("tx_tlast%0d", tx_cnt), int'(m_tlast), int'(tx_cnt == NT - 1));
          chk_w("tx_tkeep", W'(m_tkeep), W'({KW{1'b1}}));
          tx_cnt++;
          last_tx_edge = cyc + 1;
        end
        last_stall = !m_tready;
        last_data  = m_tdata;
        last_tlast = m_tlast;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '1;
      if (s_tready) begin
        if (first_srdy < 0) first_srdy = cyc;
        s_tvalid = v.rx_gaps ? (rx_step % 2 == 0) : 1'b1;
        rx_step++;
        if (s_tvalid) begin
          s_tdata = rx_word(v.seed, rx_cnt);
          s_tlast = (rx_cnt == v.tlast_at);
          s_tkeep = KW'(16'h00F0);
          rx_cnt++;
          last_rx_edge = cyc + 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; m_tready = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;

    chk_i("done_seen", int'(done_cyc >= 0), 1);
    chk_i("tx_count", tx_cnt, NT);
    chk_i("rx_count", rx_cnt, NR);
    chk_i("s_tready_rise", first_srdy, last_tx_edge);
    chk_i("done_after_rx", done_cyc, last_rx_edge);
    chk_i("latency", done_cyc + 1, v.exp_lat);
    chk_i("error", int'(error), int'(v.exp_err));
    for (int k = 0; k < NR; k++)
      chk_w($sformatf("rx_bus_w%0d", k), rx_bus[k*W +: W], rx_word(v.seed, k));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_i("post_done", int'(done), 0);
      chk_i("post_busy", int'(busy), 0);
      chk_i("post_tvalid", int'(m_tvalid), 0);
    end
    chk_i("error_held", int'(error), int'(v.exp_err));
  endtask

  task automatic check_quiet(input string tag);
    chk_i({tag, "_tvalid"}, int'(m_tvalid), 0);
    chk_i({tag, "_tlast"}, int'(m_tlast), 0);
    chk_w({tag, "_tdata"}, m_tdata, '0);
    chk_w({tag, "_tkeep"}, W'(m_tkeep), '0);
    chk_i({tag, "_s_tready"}, int'(s_tready), 0);
    chk_i({tag, "_busy"}, int'(busy), 0);
    chk_i({tag, "_done"}, int'(done), 0);
    chk_i({tag, "_error"}, int'(error), 0);
    for (int k = 0; k < NR; k++)
      chk_w($sformatf("%s_rx_bus_w%0d", tag, k), rx_bus[k*W +: W], '0);
  endtask

  initial begin
    int rx_cnt, cyc, beat3_edge, done_cyc;

    vecs[0] = '{seed: 1, tready_toggle: 0, rx_gaps: 0, tlast_at: 9,  mid_start: 0, exp_err: 0, exp_lat: 21};
    vecs[1] = '{seed: 2, tready_toggle: 1, rx_gaps: 0, tlast_at: 9,  mid_start: 0, exp_err: 0, exp_lat: 31};
    vecs[2] = '{seed: 3, tready_toggle: 0, rx_gaps: 0, tlast_at: 3,  mid_start: 0, exp_err: 1, exp_lat: 21};
    vecs[3] = '{seed: 4, tready_toggle: 0, rx_gaps: 0, tlast_at: 9,  mid_start: 3, exp_err: 0, exp_lat: 21};
    vecs[4] = '{seed: 5, tready_toggle: 0, rx_gaps: 1, tlast_at: 9,  mid_start: 0, exp_err: 0, exp_lat: 30};
    vecs[5] = '{seed: 6, tready_toggle: 0, rx_gaps: 0, tlast_at: -1, mid_start: 0, exp_err: 1, exp_lat: 21};

    areset = 1'b1; start = 1'b0; tx_bus = '0;
    m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    areset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset while beat 5 of the response is on the bus.
    tx_bus = tx_frame(7);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rx_cnt = 0;
    cyc = 0;
    while (cyc < 100 && rx_cnt < 4) begin
      m_tready = 1'b1;
      s_tvalid = 1'b0;
      if (s_tready) begin
        s_tvalid = 1'b1;
        s_tdata  = rx_word(7, rx_cnt);
        s_tlast  = 1'b0;
        rx_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk_i("rst_mid_reached", rx_cnt, 4);
    chk_i("rst_mid_in_rx", int'(s_tready), 1);
    s_tvalid = 1'b1;
    s_tdata  = rx_word(7, 4);
    areset   = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    check_quiet("rst_mid");
    areset = 1'b0;
    @(posedge clk); #1;
    run_frame(vecs[0]);

`ifdef AXIS_FRAME_HOST_TIMEOUT_EN
    // Response stalls after three beats; watchdog (16 idle cycles) must end the frame.
    tx_bus = tx_frame(9);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rx_cnt = 0; cyc = 0; beat3_edge = -1; done_cyc = -1;
    while (cyc < 200) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      m_tready = 1'b1;
      s_tvalid = 1'b0;
      if (s_tready && rx_cnt < 3) begin
        s_tvalid = 1'b1;
        s_tdata  = rx_word(9, rx_cnt);
        s_tlast  = 1'b0;
        rx_cnt++;
        if (rx_cnt == 3) beat3_edge = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_tready = 1'b0; s_tvalid = 1'b0;
    chk_i("wd_done_seen", int'(done_cyc >= 0), 1);
    chk_i("wd_latency", done_cyc + 1 - beat3_edge, 17);
    chk_i("wd_error", int'(error), 1);
    chk_i("wd_s_tready", int'(s_tready), 0);
    for (int k = 0; k < 3; k++)
      chk_w($sformatf("wd_rx_bus_w%0d", k), rx_bus[k*W +: W], rx_word(9, k));
    @(posedge clk); #1;
    chk_i("wd_idle_busy", int'(busy), 0);
`else
    rx_cnt = 0; cyc = 0; beat3_edge = 0; done_cyc = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
